// File: rtl/frame_packetizer_pkg.sv
// Shared types and header-layout helpers for the frame packetizer.
package frame_packetizer_pkg;

  localparam int unsigned MODE_LEN = 8;
  localparam int unsigned LENF_LEN = 16;
  localparam int unsigned LEN_W    = 16;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_HDR   = 6'b000010,
    ST_PLD   = 6'b000100,
    ST_PAD   = 6'b001000,
    ST_DRAIN = 6'b010000,
    ST_GAP   = 6'b100000
  } state_e;

  // Header field offsets: [preamble|sync|mode|length|tail]
  function automatic int unsigned mode_off(input int unsigned pre_len, input int unsigned sync_len);
    return pre_len + sync_len;
  endfunction

  function automatic int unsigned lenf_off(input int unsigned pre_len, input int unsigned sync_len);
    return mode_off(pre_len, sync_len) + MODE_LEN;
  endfunction

  function automatic int unsigned tail_off(input int unsigned pre_len, input int unsigned sync_len);
    return lenf_off(pre_len, sync_len) + LENF_LEN;
  endfunction

  function automatic int unsigned hdr_len(input int unsigned pre_len, input int unsigned sync_len,
                                          input int unsigned tail_len);
    return tail_off(pre_len, sync_len) + tail_len;
  endfunction

  // Payload beat count: BPSK one bit per beat, QPSK two bits per beat rounded up
  function automatic logic [LEN_W-1:0] calc_beats(input logic mode, input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = (LEN_W+1)'(len) + (LEN_W+1)'(1);
    return mode ? len : LEN_W'(sum >> 1);
  endfunction

endpackage

// File: rtl/frame_packetizer_hdr_gen.sv
// Combinational header symbol lookup: header index, mode and length to one header bit.
module frame_packetizer_hdr_gen
  import frame_packetizer_pkg::*;
#(
  parameter int unsigned PRE_LEN  = 224,
  parameter int unsigned SYNC_LEN = 32,
  parameter int unsigned IDX_W    = 9
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  output logic             hdr_bit_c
);

  localparam int unsigned SYNC_OFF = PRE_LEN;
  localparam int unsigned MODE_OFF = mode_off(PRE_LEN, SYNC_LEN);
  localparam int unsigned LENF_OFF = lenf_off(PRE_LEN, SYNC_LEN);
  localparam int unsigned TAIL_OFF = tail_off(PRE_LEN, SYNC_LEN);
  localparam int unsigned POS_W    = $clog2(LENF_LEN);

  logic [POS_W-1:0] len_pos;

  // Length field goes out MSB first, so bit index is the inverted field position
  always_comb begin
    len_pos = POS_W'(idx - IDX_W'(LENF_OFF));
    if (idx < IDX_W'(SYNC_OFF)) begin
      hdr_bit_c = idx[0];
    end else if (idx < IDX_W'(MODE_OFF)) begin
      hdr_bit_c = ~idx[0];
    end else if (idx < IDX_W'(LENF_OFF)) begin
      hdr_bit_c = mode ^ idx[0];
    end else if (idx < IDX_W'(TAIL_OFF)) begin
      hdr_bit_c = len[~len_pos];
    end else begin
      hdr_bit_c = idx[0];
    end
  end

endmodule

// File: rtl/frame_packetizer.sv
// Frames a payload AXIS stream with a fixed header and enforced idle gap, feeding the PSK modulator.
module frame_packetizer
  import frame_packetizer_pkg::*;
#(
  parameter int unsigned BYTES    = 1,
  parameter int unsigned PRE_LEN  = 224,
  parameter int unsigned SYNC_LEN = 32,
  parameter int unsigned TAIL_LEN = 40,
  parameter int unsigned GAP_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_W-1:0]     payload_length,
  input  logic [BYTES*8-1:0]   in_tdata,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic                 in_tlast,
  input  logic                 in_tuser,
  output logic [BYTES*8-1:0]   out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tlast,
  output logic                 out_tuser,
  output logic                 hdr_vld,
  output logic                 busy,
  output logic                 err_len
);

  localparam int unsigned DW       = BYTES * 8;
  localparam int unsigned HDR_LEN  = hdr_len(PRE_LEN, SYNC_LEN, TAIL_LEN);
  localparam int unsigned IDX_W    = $clog2(HDR_LEN);
  localparam int unsigned GAP_W    = $clog2(GAP_LEN + 1);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  state_e             state, state_n;
  logic [IDX_W-1:0]   hdr_idx, hdr_idx_n;
  logic [LEN_W-1:0]   pld_cnt, pld_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               mode_q, mode_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   n_beats, n_beats_n;
  logic [DW-1:0]      out_tdata_n;
  logic               out_tvalid_n, out_tlast_n, out_tuser_n, hdr_vld_n, busy_n, err_len_n;

  logic               load_c, in_tready_c, hdr_last_c, pld_last_c, hdr_bit_c;

  frame_packetizer_hdr_gen #(
    .PRE_LEN  (PRE_LEN),
    .SYNC_LEN (SYNC_LEN),
    .IDX_W    (IDX_W)
  ) u_hdr_gen (
    .idx       (hdr_idx),
    .mode      (mode_q),
    .len       (len_q),
    .hdr_bit_c (hdr_bit_c)
  );

  // Output register may take a new beat when empty or being accepted this cycle
  assign load_c      = ~out_tvalid | out_tready;
  assign in_tready_c = ((state == ST_PLD) || (state == ST_DRAIN)) && load_c;
  assign in_tready   = in_tready_c;
  assign hdr_last_c  = (hdr_idx == HDR_LAST);
  assign pld_last_c  = ((LEN_W+1)'(pld_cnt) + (LEN_W+1)'(1)) == (LEN_W+1)'(n_beats);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hdr_idx    <= '0;
      pld_cnt    <= '0;
      gap_cnt    <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      n_beats    <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b1;
      hdr_vld    <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_n;
      hdr_idx    <= hdr_idx_n;
      pld_cnt    <= pld_cnt_n;
      gap_cnt    <= gap_cnt_n;
      mode_q     <= mode_n;
      len_q      <= len_n;
      n_beats    <= n_beats_n;
      out_tdata  <= out_tdata_n;
      out_tvalid <= out_tvalid_n;
      out_tlast  <= out_tlast_n;
      out_tuser  <= out_tuser_n;
      hdr_vld    <= hdr_vld_n;
      busy       <= busy_n;
      err_len    <= err_len_n;
    end
  end

  always_comb begin
    state_n      = state;
    hdr_idx_n    = hdr_idx;
    pld_cnt_n    = pld_cnt;
    gap_cnt_n    = gap_cnt;
    mode_n       = mode_q;
    len_n        = len_q;
    n_beats_n    = n_beats;
    out_tdata_n  = out_tdata;
    out_tvalid_n = out_tvalid;
    out_tlast_n  = out_tlast;
    out_tuser_n  = out_tuser;
    hdr_vld_n    = hdr_vld;
    err_len_n    = 1'b0;

    // Accepted or empty register drops to idle unless a state loads a new beat below
    if (load_c) begin
      out_tvalid_n = 1'b0;
      out_tlast_n  = 1'b0;
      hdr_vld_n    = 1'b0;
    end

    unique case (state)
      ST_IDLE: begin
        if (in_tvalid) begin
          mode_n    = in_tuser;
          len_n     = payload_length;
          n_beats_n = calc_beats(in_tuser, payload_length);
          hdr_idx_n = '0;
          pld_cnt_n = '0;
          gap_cnt_n = '0;
          state_n   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (load_c) begin
          out_tvalid_n = 1'b1;
          out_tdata_n  = {DW{hdr_bit_c}};
          out_tuser_n  = 1'b1;
          hdr_vld_n    = 1'b1;
          out_tlast_n  = hdr_last_c && (n_beats == '0);
          if (hdr_last_c) begin
            state_n = (n_beats == '0) ? ST_GAP : ST_PLD;
          end else begin
            hdr_idx_n = hdr_idx + IDX_W'(1);
          end
        end
      end
      ST_PLD: begin
        if (load_c && in_tvalid) begin
          out_tvalid_n = 1'b1;
          out_tdata_n  = in_tdata;
          out_tuser_n  = mode_q;
          out_tlast_n  = pld_last_c;
          pld_cnt_n    = pld_cnt + LEN_W'(1);
          if (pld_last_c) begin
            if (in_tlast) begin
              state_n = ST_GAP;
            end else begin
              err_len_n = 1'b1;
              state_n   = ST_DRAIN;
            end
          end else if (in_tlast) begin
            err_len_n = 1'b1;
            state_n   = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (load_c) begin
          out_tvalid_n = 1'b1;
          out_tdata_n  = '0;
          out_tuser_n  = mode_q;
          out_tlast_n  = pld_last_c;
          pld_cnt_n    = pld_cnt + LEN_W'(1);
          if (pld_last_c) state_n = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (in_tready_c && in_tvalid && in_tlast) state_n = ST_GAP;
      end
      ST_GAP: begin
        // Count only cycles where the final beat has already left the register
        if (!out_tvalid) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_n = '0;
            state_n   = ST_IDLE;
          end else begin
            gap_cnt_n = gap_cnt + GAP_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_frame_packetizer.sv
// Scoreboard bench for frame_packetizer: directed frames, backpressure, length errors, reset abort.
module tb_frame_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] payload_length;
  logic [7:0]  in_tdata;
  logic        in_tvalid, in_tready, in_tlast, in_tuser;
  logic [7:0]  out_tdata;
  logic        out_tvalid, out_tready, out_tlast, out_tuser;
  logic        hdr_vld, busy, err_len;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
    logic       hdr;
  } beat_t;

  beat_t exp_q[$];
  beat_t hold_b;
  bit    hold_vld  = 0;
  int    gap_left  = 0;
  int    checks    = 0;
  int    errors    = 0;
  int    err_seen  = 0;
  int    beat_cnt  = 0;
  bit    rand_ready = 0;

  frame_packetizer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .payload_length (payload_length),
    .in_tdata       (in_tdata),
    .in_tvalid      (in_tvalid),
    .in_tready      (in_tready),
    .in_tlast       (in_tlast),
    .in_tuser       (in_tuser),
    .out_tdata      (out_tdata),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .out_tlast      (out_tlast),
    .out_tuser      (out_tuser),
    .hdr_vld        (hdr_vld),
    .busy           (busy),
    .err_len        (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference header for the default 224/32/8/16/40 layout
  function automatic logic hdr_model(input int i, input logic mode, input logic [15:0] len);
    if (i < 224)      return i[0];
    else if (i < 256) return ~i[0];
    else if (i < 264) return mode ^ i[0];
    else if (i < 280) return len[15 - (i - 264)];
    else              return i[0];
  endfunction

  task automatic push_frame(input logic mode, input logic [15:0] len, input int n_exp,
                            input int src_cnt, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < 320; i++) begin
      b.d    = {8{hdr_model(i, mode, len)}};
      b.last = (i == 319) && (n_exp == 0);
      b.user = 1'b1;
      b.hdr  = 1'b1;
      exp_q.push_back(b);
    end
    for (int k = 1; k <= n_exp; k++) begin
      b.d    = (k <= src_cnt) ? 8'(base + 8'(k - 1)) : 8'h00;
      b.last = (k == n_exp);
      b.user = mode;
      b.hdr  = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  // Output monitor: compares accepted beats, stall stability and the idle gap
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 0;
      gap_left = 0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!out_tvalid || {out_tdata, out_tlast, out_tuser, hdr_vld} !== hold_b) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h expected %h", out_tvalid,
                   {out_tdata, out_tlast, out_tuser, hdr_vld}, hold_b);
        end
        hold_vld = 0;
      end
      if (gap_left > 0) begin
        chk("gap_idle", 32'(out_tvalid), 32'd0);
        gap_left--;
      end
      if (out_tvalid) begin
        if (out_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h with empty scoreboard",
                     {out_tdata, out_tlast, out_tuser, hdr_vld});
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            if ({out_tdata, out_tlast, out_tuser, hdr_vld} !== e) begin
              errors++;
              $display("FAIL beat%0d: got d=%h last=%b user=%b hdr=%b expected d=%h last=%b user=%b hdr=%b",
                       beat_cnt, out_tdata, out_tlast, out_tuser, hdr_vld, e.d, e.last, e.user, e.hdr);
            end
          end
          beat_cnt++;
          if (out_tlast) gap_left = 4;
        end else begin
          hold_b   = {out_tdata, out_tlast, out_tuser, hdr_vld};
          hold_vld = 1;
        end
      end
      if (err_len) err_seen++;
    end
  end

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Source driver; header fields are scrambled after the first payload handshake
  task automatic drive_src(input int cnt, input logic mode, input logic [15:0] len,
                           input logic [7:0] base, input bit bubbles);
    payload_length = len;
    in_tuser       = mode;
    if (cnt == 0) begin
      in_tdata  = 8'h00;
      in_tlast  = 1'b1;
      in_tvalid = 1'b1;
      @(posedge clk);
      #1;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      int t;
      bit hs;
      in_tdata  = 8'(base + 8'(i));
      in_tlast  = (i == cnt - 1);
      in_tvalid = 1'b1;
      t  = 0;
      hs = 0;
      while (!hs && t < 4000) begin
        @(negedge clk);
        hs = in_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL src_timeout: beat %0d never accepted, got 0 expected 1", i);
        in_tvalid = 1'b0;
        return;
      end
      payload_length = 16'hFFFF;
      in_tuser       = ~mode;
      if (bubbles && i < cnt - 1) begin
        in_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy || gap_left != 0) && t < 10000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 10000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic run_frame(input string name, input logic mode, input logic [15:0] len,
                           input int n_exp, input int src_cnt, input logic [7:0] base,
                           input bit bubbles, input int exp_err);
    push_frame(mode, len, n_exp, src_cnt, base);
    err_seen = 0;
    drive_src(src_cnt, mode, len, base, bubbles);
    wait_done(name);
    chk({name, "_err_len"}, 32'(err_seen), 32'(exp_err));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    payload_length = '0;
    in_tdata       = '0;
    in_tvalid      = 1'b0;
    in_tlast       = 1'b0;
    in_tuser       = 1'b0;
    #12;
    chk("rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_tuser",  32'(out_tuser),  32'd1);
    chk("rst_tlast",  32'(out_tlast),  32'd0);
    chk("rst_hdr",    32'(hdr_vld),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_tready", 32'(in_tready),  32'd0);
    chk("rst_tdata",  32'(out_tdata),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame("bpsk4",    1'b1, 16'd4, 4, 4, 8'hA0, 1'b0, 0);
    run_frame("qpsk5",    1'b0, 16'd5, 3, 3, 8'hB0, 1'b0, 0);
    rand_ready = 1;
    run_frame("bpsk4_bp", 1'b1, 16'd4, 4, 4, 8'hA0, 1'b1, 0);
    run_frame("qpsk1_bp", 1'b0, 16'd1, 1, 1, 8'hE0, 1'b0, 0);
    rand_ready = 0;
    run_frame("early",    1'b1, 16'd8, 8, 5, 8'hC0, 1'b0, 1);
    run_frame("late",     1'b1, 16'd2, 2, 4, 8'hD0, 1'b0, 1);
    run_frame("len0",     1'b1, 16'd0, 0, 0, 8'h00, 1'b0, 0);

    // Abort a frame part-way through its header
    push_frame(1'b1, 16'd16, 16, 16, 8'h55);
    beat_cnt       = 0;
    payload_length = 16'd16;
    in_tuser       = 1'b1;
    in_tdata       = 8'h55;
    in_tlast       = 1'b0;
    in_tvalid      = 1'b1;
    begin
      int t = 0;
      while (beat_cnt < 100 && t < 2000) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("abort_reach_hdr100", 32'(beat_cnt >= 100), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_tvalid = 1'b0;
    chk("abort_tvalid", 32'(out_tvalid), 32'd0);
    chk("abort_tlast",  32'(out_tlast),  32'd0);
    chk("abort_hdr",    32'(hdr_vld),    32'd0);
    chk("abort_busy",   32'(busy),       32'd0);
    chk("abort_tuser",  32'(out_tuser),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", 32'(out_tvalid), 32'd0);

    run_frame("recover", 1'b1, 16'd4, 4, 4, 8'hA0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
